// File: rtl/dram_rd_engine.sv
// dram_rd_engine: round-robin AXI4 read-burst engine for NCH requesters.
// Requests crossing a 4 KB page are split into two INCR bursts, and returned
// beats are passed straight through as one tagged, back-pressured stream.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrating from rr_ptr
// AR     | presenting the current burst on the read address channel
// DATA   | forwarding R beats until rlast of the current burst
module dram_rd_engine #(
  parameter int          NCH  = 2,
  parameter int          DW   = 128,
  parameter int          AW   = 32,
  parameter int          LENW = 8,
  parameter logic [3:0]  ID   = 4'd0,
  parameter int          CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*LENW-1:0]   req_len,
  output logic [3:0]            arid_s_inf,
  output logic [AW-1:0]         araddr_s_inf,
  output logic [7:0]            arlen_s_inf,
  output logic [2:0]            arsize_s_inf,
  output logic [1:0]            arburst_s_inf,
  output logic                  arvalid_s_inf,
  input  logic                  arready_s_inf,
  input  logic [3:0]            rid_s_inf,
  input  logic [DW-1:0]         rdata_s_inf,
  input  logic [1:0]            rresp_s_inf,
  input  logic                  rlast_s_inf,
  input  logic                  rvalid_s_inf,
  output logic                  rready_s_inf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_last,
  output logic                  err
);

  localparam int BYTES = DW / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA} state_t;

  state_t          state;
  logic [CHW-1:0]  ch_q;
  logic [CHW-1:0]  rr_ptr;
  logic [CHW-1:0]  rr_next;
  logic            seg1_pend;
  logic [AW-1:0]   seg1_addr;
  logic [7:0]      seg1_len;

  logic            grant_found;
  logic [CHW-1:0]  grant_idx;
  logic [AW-1:0]   sel_addr;
  logic [LENW-1:0] sel_len;
  logic [AW-1:0]   aligned;
  logic [12:0]     len_ext;
  logic [12:0]     room;
  logic [12:0]     page_rem;
  logic            split;
  logic            r_hs;
  logic            unused_ok;

  // Round-robin search for the first valid channel at or after rr_ptr.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr_ptr) + i) % NCH;
      if (!grant_found && req_valid[CHW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CHW'(idx);
      end
    end
  end

  // One-hot accept for the granted channel, only while idle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Page-split arithmetic on the granted request; room is in beats.
  always_comb begin
    sel_addr = req_addr[grant_idx*AW +: AW];
    sel_len  = req_len[grant_idx*LENW +: LENW];
    aligned  = {sel_addr[AW-1:BSH], {BSH{1'b0}}};
    len_ext  = 13'(sel_len);
    page_rem = 13'd4096 - {1'b0, aligned[11:0]};
    room     = page_rem >> BSH;
    split    = (len_ext + 13'd1) > room;
  end

  assign rr_next   = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
  assign r_hs      = rvalid_s_inf & rready_s_inf;
  assign unused_ok = ^{rid_s_inf, sel_addr[BSH-1:0]};

  // Request sequencing: accept, issue one or two bursts, forward data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      arvalid_s_inf <= 1'b0;
      araddr_s_inf  <= '0;
      arlen_s_inf   <= '0;
      ch_q          <= '0;
      rr_ptr        <= '0;
      seg1_pend     <= 1'b0;
      seg1_addr     <= '0;
      seg1_len      <= '0;
      err           <= 1'b0;
    end else begin
      if (r_hs && rresp_s_inf != 2'b00) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            ch_q          <= grant_idx;
            araddr_s_inf  <= aligned;
            arvalid_s_inf <= 1'b1;
            state         <= S_AR;
            if (split) begin
              arlen_s_inf <= 8'(room - 13'd1);
              seg1_pend   <= 1'b1;
              seg1_addr   <= aligned + AW'(page_rem);
              seg1_len    <= 8'(len_ext - room);
            end else begin
              arlen_s_inf <= 8'(len_ext);
              seg1_pend   <= 1'b0;
            end
          end
        end
        S_AR: begin
          if (arready_s_inf) begin
            arvalid_s_inf <= 1'b0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs && rlast_s_inf) begin
            if (seg1_pend) begin
              araddr_s_inf  <= seg1_addr;
              arlen_s_inf   <= seg1_len;
              arvalid_s_inf <= 1'b1;
              seg1_pend     <= 1'b0;
              state         <= S_AR;
            end else begin
              rr_ptr <= rr_next;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arid_s_inf    = ID;
  assign arsize_s_inf  = 3'(BSH);
  assign arburst_s_inf = 2'b01;
  assign rready_s_inf  = (state == S_DATA) & out_ready;
  assign out_valid     = (state == S_DATA) & rvalid_s_inf;
  assign out_data      = rdata_s_inf;
  assign out_ch        = ch_q;
  assign out_last      = (state == S_DATA) & rlast_s_inf & ~seg1_pend;

endmodule
